uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small receive FIFO. Sits between the external RXD pin and the SOC memory-mapped UART register that the CPU polls.
- Oversamples RXD with the system clock, validates start and stop bits, and pushes good bytes into a first-word-fall-through FIFO.
- The CPU drains the FIFO with a single-cycle read strobe. Sticky error flags report framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 218, system clocks per UART bit (10 MHz / 218 ≈ 45.9 kbaud); must be ≥ 4.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- rxd  input  1  raw serial input; idle high.
- rd_en  input  1  pop strobe; consumes the head entry when rx_valid=1, ignored otherwise.
- clr_err  input  1  one-cycle pulse; clears frame_err and overrun.
- rd_data  output  8  head FIFO entry (FWFT); forced to 8'h00 when the FIFO is empty.
- rx_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a valid byte arrived while the FIFO was full.

Behaviour:
- Reset (resetn=0, asynchronous):
  - synchroniser flops=1, state=IDLE, counters=0, FIFO pointers=0.
  - rd_data=0, rx_valid=0, fifo_count=0, frame_err=0, overrun=0.
  - Reset mid-frame aborts the byte; nothing is pushed.
- Synchroniser: rxd passes through 2 flops to give rxd_s. All FSM decisions use rxd_s only.
- FSM states and transitions:
  - IDLE: when rxd_s=0, go to START with clk_cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample rxd_s.
    - rxd_s=0: go to DATA, clk_cnt=0, bit_idx=0.
    - rxd_s=1: glitch; return to IDLE and push nothing.
  - DATA: count to CLKS_PER_BIT-1, then sample rxd_s into the shift register, LSB first.
    - After bit_idx=7, go to STOP; otherwise increment bit_idx.
  - STOP: count to CLKS_PER_BIT-1, then sample rxd_s and return to IDLE on that same edge, mid stop bit. This allows back-to-back frames.
    - rxd_s=1: push the byte.
    - rxd_s=0: set frame_err and discard the byte.
- Push:
  - Pushed data appears on rd_data, with rx_valid=1, in the cycle after the stop-sample edge.
  - Push while full: byte dropped, overrun set, FIFO unchanged.
- Pop: rd_en=1 with rx_valid=1 advances the read pointer; rd_data shows the next entry the following cycle.
- Simultaneous push and pop:
  - Full: pop and push both succeed; count stays at DEPTH; no overrun.
  - Empty: rd_en is ignored and the push succeeds.
  - Otherwise: count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count tracks exact occupancy.
- Sticky flags:
  - Set has priority over clr_err in the same cycle.
  - Flags never affect reception.
- Latency: a stop-bit midpoint on the pin reaches rx_valid=1 after 2 synchroniser cycles plus 1 cycle.

Test Plan:
- Single byte: reset, send 0x35 at CLKS_PER_BIT=218 → rx_valid=1, rd_data=0x35, fifo_count=1; pulse rd_en → rx_valid=0, rd_data=0x00, fifo_count=0.
- Overrun and wrap: send 0x35, 0x37, 0x38, 0x38, 0x0D with no reads → fifo_count=4, overrun=1.
  - Pop sequence yields 0x35, 0x37, 0x38, 0x38, then empty.
  - Refill with 0x32, 0x37 → reads 0x32, 0x37 (pointer wrap).
- Glitch and framing: hold rxd low for 50 clocks, then high → no push, flags 0.
  - Send 0x33 with the stop bit held low → frame_err=1, fifo_count unchanged.
  - clr_err → frame_err=0.
- Push/pop collision: with FIFO full, assert rd_en on the exact push cycle → count stays 4, overrun=0, order preserved.
- Reset mid-frame: deassert resetn during DATA bit 4 of 0x41, release, then send 0x0D → only 0x0D received, fifo_count=1.
- Back-to-back: send 0x55, 0xAA with no idle gap between the stop bit and the next start bit → both received in order, no errors.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// CPU-side register interface of the UART receiver: the FIFO head, its occupancy and the sticky error flags.
// The master modport is the polling CPU, the slave modport is the receiver.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             rd_en;
    logic             clr_err;
    logic [7:0]       rd_data;
    logic             rx_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             frame_err;
    logic             overrun;

    modport master (
        output rd_en,
        output clr_err,
        input  rd_data,
        input  rx_valid,
        input  fifo_count,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rd_en,
        input  clr_err,
        output rd_data,
        output rx_valid,
        output fifo_count,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a first-word-fall-through receive FIFO
// with sticky framing-error and overrun flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 218,
    parameter int DEPTH        = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           rxd,
    uart_rx_fifo_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(CLKS_PER_BIT);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic                rxd_m;
    logic                rxd_s;
    logic [TICK_W-1:0]   clk_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;

    logic [7:0]          mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                frame_err;
    logic                overrun;

    logic                stop_tick;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;

    // Synchroniser idles high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // The stop sample writes the FIFO on the same edge, so the byte is visible the very next cycle.
    assign stop_tick = (state == STOP) && (clk_cnt == BIT_LAST);
    assign push      = stop_tick && rxd_s;
    assign full      = (count == FULL);
    assign pop       = bus.rd_en && (count != '0);
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting wins over a same-cycle clear so an error is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_tick && !rxd_s) begin
                frame_err <= 1'b1;
            end else if (bus.clr_err) begin
                frame_err <= 1'b0;
            end
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end else if (bus.clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.rx_valid   = (count != '0);
    assign bus.fifo_count = count;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven on rxd with hand-computed FIFO contents and flags.
module tb_uart_rx_fifo;
    localparam int CPB   = 218;
    localparam int DEPTH = 4;

    logic clk;
    logic resetn;
    logic rxd;
    int   n_compared;
    int   n_mismatched;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rxd(rxd),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each bit is set on a falling edge and held CPB clocks; optional pop lands on the stop-sample edge.
    task automatic send_byte(input logic [7:0] data, input logic stop_level, input bit pop_at_stop);
        logic [9:0] frame;
        frame = {stop_level, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            if (i == 9 && pop_at_stop) begin
                repeat (111) @(negedge clk);
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
                repeat (CPB - 113) @(negedge clk);
            end else begin
                repeat (CPB - 1) @(negedge clk);
            end
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        rxd         = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (4) @(negedge clk);
        n_compared++;
        if (bus.rx_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_valid: got %b want 0", bus.rx_valid);
        end
        n_compared++;
        if (bus.rd_data !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got %h want 00", bus.rd_data);
        end
        n_compared++;
        if (bus.fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count: got %0d want 0", bus.fifo_count);
        end
        n_compared++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got fe=%b ov=%b want 0 0", bus.frame_err, bus.overrun);
        end
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        send_byte(8'h35, 1'b1, 1'b0);
        n_compared++;
        if (bus.rx_valid !== 1'b1 || bus.rd_data !== 8'h35 || bus.fifo_count !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL single_rx: got v=%b d=%h c=%0d want 1 35 1", bus.rx_valid, bus.rd_data, bus.fifo_count);
        end
        pop_one();
        n_compared++;
        if (bus.rx_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL single_pop: got v=%b d=%h c=%0d want 0 00 0", bus.rx_valid, bus.rd_data, bus.fifo_count);
        end
    endtask

    task automatic test_overrun_wrap();
        logic [7:0] sent [5];
        logic [7:0] want [4];
        logic [7:0] refill [2];
        sent   = '{8'h35, 8'h37, 8'h38, 8'h38, 8'h0D};
        want   = '{8'h35, 8'h37, 8'h38, 8'h38};
        refill = '{8'h32, 8'h37};
        foreach (sent[i]) send_byte(sent[i], 1'b1, 1'b0);
        n_compared++;
        if (bus.fifo_count !== 3'd4 || bus.overrun !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_full: got c=%0d ov=%b want 4 1", bus.fifo_count, bus.overrun);
        end
        n_compared++;
        if (bus.frame_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_fe: got %b want 0", bus.frame_err);
        end
        foreach (want[i]) begin
            n_compared++;
            if (bus.rx_valid !== 1'b1 || bus.rd_data !== want[i]) begin
                n_mismatched++;
                $display("[TB] FAIL overrun_pop%0d: got v=%b d=%h want 1 %h", i, bus.rx_valid, bus.rd_data, want[i]);
            end
            pop_one();
        end
        n_compared++;
        if (bus.rx_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_empty: got v=%b c=%0d want 0 0", bus.rx_valid, bus.fifo_count);
        end
        foreach (refill[i]) send_byte(refill[i], 1'b1, 1'b0);
        foreach (refill[i]) begin
            n_compared++;
            if (bus.rx_valid !== 1'b1 || bus.rd_data !== refill[i]) begin
                n_mismatched++;
                $display("[TB] FAIL wrap_pop%0d: got v=%b d=%h want 1 %h", i, bus.rx_valid, bus.rd_data, refill[i]);
            end
            pop_one();
        end
        pulse_clr();
        n_compared++;
        if (bus.overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_clear: got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_glitch_framing();
        @(negedge clk);
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        n_compared++;
        if (bus.fifo_count !== 3'd0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL glitch: got c=%0d fe=%b ov=%b want 0 0 0", bus.fifo_count, bus.frame_err, bus.overrun);
        end
        send_byte(8'h33, 1'b0, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        n_compared++;
        if (bus.frame_err !== 1'b1 || bus.fifo_count !== 3'd0 || bus.overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL framing: got fe=%b c=%0d ov=%b want 1 0 0", bus.frame_err, bus.fifo_count, bus.overrun);
        end
        pulse_clr();
        n_compared++;
        if (bus.frame_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL framing_clear: got %b want 0", bus.frame_err);
        end
    endtask

    task automatic test_collision();
        logic [7:0] fill [4];
        logic [7:0] want [4];
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
        want = '{8'h22, 8'h33, 8'h44, 8'h55};
        foreach (fill[i]) send_byte(fill[i], 1'b1, 1'b0);
        n_compared++;
        if (bus.fifo_count !== 3'd4 || bus.rd_data !== 8'h11) begin
            n_mismatched++;
            $display("[TB] FAIL collide_fill: got c=%0d d=%h want 4 11", bus.fifo_count, bus.rd_data);
        end
        send_byte(8'h55, 1'b1, 1'b1);
        n_compared++;
        if (bus.fifo_count !== 3'd4 || bus.overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL collide_count: got c=%0d ov=%b want 4 0", bus.fifo_count, bus.overrun);
        end
        foreach (want[i]) begin
            n_compared++;
            if (bus.rx_valid !== 1'b1 || bus.rd_data !== want[i]) begin
                n_mismatched++;
                $display("[TB] FAIL collide_pop%0d: got v=%b d=%h want 1 %h", i, bus.rx_valid, bus.rd_data, want[i]);
            end
            pop_one();
        end
        n_compared++;
        if (bus.fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL collide_empty: got c=%0d want 0", bus.fifo_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rxd = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = frame[5];
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        n_compared++;
        if (bus.fifo_count !== 3'd0 || bus.rx_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_hold: got c=%0d v=%b want 0 0", bus.fifo_count, bus.rx_valid);
        end
        resetn = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h0D, 1'b1, 1'b0);
        n_compared++;
        if (bus.fifo_count !== 3'd1 || bus.rd_data !== 8'h0D || bus.frame_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_rx: got c=%0d d=%h fe=%b want 1 0d 0", bus.fifo_count, bus.rd_data, bus.frame_err);
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        n_compared++;
        if (bus.fifo_count !== 3'd2 || bus.rd_data !== 8'h55) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first: got c=%0d d=%h want 2 55", bus.fifo_count, bus.rd_data);
        end
        pop_one();
        n_compared++;
        if (bus.fifo_count !== 3'd1 || bus.rd_data !== 8'hAA) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second: got c=%0d d=%h want 1 aa", bus.fifo_count, bus.rd_data);
        end
        pop_one();
        n_compared++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0 || bus.rx_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_flags: got fe=%b ov=%b v=%b want 0 0 0", bus.frame_err, bus.overrun, bus.rx_valid);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_single_byte();
        test_overrun_wrap();
        test_glitch_framing();
        test_collision();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
